// File: rtl/heartbeat_pkg.sv
// heartbeat_pkg: shared types and constants for the heartbeat detector.
// Optional build macro HB_AVG_EN (see heartbeat_detector.sv).
package heartbeat_pkg;

    localparam int BPM_NUMERATOR = 60000;

    // Record presented on IO_HEARTBEAT
    typedef struct packed {
        logic        overrun;
        logic        timeout;
        logic [5:0]  seq;
        logic [7:0]  bpm;
        logic [15:0] interval;
    } hb_record_t;

    // Record request from the detector to the output FSM
    typedef struct packed {
        logic        timeout;
        logic [15:0] interval;
        logic [15:0] divisor;
    } hb_req_t;

    typedef enum logic {
        DET_ARMED,
        DET_FIRED
    } det_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_DIV,
        OUT_RDY,
        OUT_ACKLO
    } out_state_t;

    // Quotient clipped to the 8-bit bpm field
    function automatic logic [7:0] sat_bpm(input logic [15:0] q);
        return (q[15:8] != 8'd0) ? 8'hFF : q[7:0];
    endfunction

endpackage

// File: rtl/hb_divider.sv
// hb_divider: W/W restoring divider, start/busy/done, fixed W+1 cycle latency
// from the start edge to the done pulse. Divide by zero yields all-ones.
module hb_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W);

    logic [CW-1:0] cnt;
    logic [W-1:0]  rem;
    logic [W-1:0]  quo;
    logic [W-1:0]  dsr;
    logic [W:0]    rem_sh;
    logic          take;

    assign quotient  = quo;
    assign remainder = rem;

    // One restoring step: shift in next dividend bit, subtract if it fits
    always_comb begin
        rem_sh = {rem, quo[W-1]};
        take   = (rem_sh >= {1'b0, dsr});
    end

    // W shift/subtract steps, then one cycle to raise done
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            quo  <= '0;
            dsr  <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy <= 1'b1;
                    cnt  <= '0;
                    rem  <= '0;
                    quo  <= dividend;
                    dsr  <= divisor;
                end
            end else if (cnt == LAST) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                rem <= take ? (rem_sh[W-1:0] - dsr) : rem_sh[W-1:0];
                quo <= {quo[W-2:0], take};
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/heartbeat_detector.sv
// heartbeat_detector: hysteresis beat detector with refractory window,
// ms interval timing, timeout records, BPM via sequential divide, and a
// 4-phase RDY/ACK record handshake with a one-deep pending buffer.
// Optional macro HB_AVG_EN: divide by the mean of the last 4 intervals.
module heartbeat_detector
    import heartbeat_pkg::*;
#(
    parameter int                  TICK_DIV   = 50000,
    parameter int                  SAMPLE_W   = 12,
    parameter logic [SAMPLE_W-1:0] THRESH_HI  = SAMPLE_W'(2600),
    parameter logic [SAMPLE_W-1:0] THRESH_LO  = SAMPLE_W'(2200),
    parameter int                  REFRACT_MS = 250,
    parameter int                  TIMEOUT_MS = 3000
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                IO_READ_ACK,
    output logic [31:0]         IO_HEARTBEAT,
    output logic                IO_READ_RDY,
    output logic                beat_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
    localparam logic [15:0]   REFRACT   = 16'(REFRACT_MS);
    localparam logic [15:0]   TIMEOUT_V = 16'(TIMEOUT_MS);

    logic [PW-1:0] presc;
    logic          ms_tick;
    logic [15:0]   ms_since;
    logic          first_beat;
    det_state_t    det_q, det_d;
    logic          crossing, beat_accept, timeout_hit;
    logic [15:0]   divisor;
    logic          req_new;
    hb_req_t       req_rec, pend_req, launch_req;
    logic          pend_valid, overrun;
    logic          can_launch, launch, launch_pend, launch_new;
    out_state_t    out_q, out_d;
    hb_record_t    rec_q, rec_nxt;
    logic [5:0]    seq;
    logic [15:0]   cur_interval;
    logic          div_start, div_busy, div_done, load_rec;
    logic [15:0]   div_quo, div_rem;
    logic          div_unused;

    assign ms_tick      = (presc == PRE_MAX);
    assign IO_HEARTBEAT = rec_q;
    // Remainder and busy are not needed to form the BPM value
    assign div_unused   = ^{div_busy, div_rem};

    // 1 ms prescaler
    always_ff @(posedge HCLK) begin
        if (HRESET) presc <= '0;
        else        presc <= ms_tick ? '0 : presc + 1'b1;
    end

    // Hysteresis detector: ARMED -> FIRED on high crossing, back on low
    always_comb begin
        det_d    = det_q;
        crossing = 1'b0;
        if (sample_valid) begin
            if (det_q == DET_ARMED && sample >= THRESH_HI) begin
                det_d    = DET_FIRED;
                crossing = 1'b1;
            end else if (det_q == DET_FIRED && sample <= THRESH_LO) begin
                det_d = DET_ARMED;
            end
        end
        beat_accept = crossing && (first_beat || ms_since >= REFRACT);
        // A beat in the same cycle suppresses the timeout
        timeout_hit = !first_beat && !beat_accept && (ms_since >= TIMEOUT_V);
    end

    // Interval timer, first-beat flag, detector state, beat strobe
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ms_since   <= '0;
            first_beat <= 1'b1;
            det_q      <= DET_ARMED;
            beat_pulse <= 1'b0;
        end else begin
            det_q      <= det_d;
            beat_pulse <= beat_accept;
            if (beat_accept)
                ms_since <= '0;
            else if (ms_tick && ms_since != 16'hFFFF)
                ms_since <= ms_since + 16'd1;
            if (beat_accept)
                first_beat <= 1'b0;
            else if (timeout_hit)
                first_beat <= 1'b1;
        end
    end

`ifdef HB_AVG_EN
    logic [3:0][15:0] hist, hist_nxt;
    logic             hist_fill;
    logic [17:0]      hist_sum;

    // Divisor is the mean of the newest four intervals
    always_comb begin
        hist_nxt = hist_fill ? {4{ms_since}} : {hist[2:0], ms_since};
        hist_sum = 18'(hist_nxt[0]) + 18'(hist_nxt[1])
                 + 18'(hist_nxt[2]) + 18'(hist_nxt[3]);
        divisor  = hist_sum[17:2];
    end

    // History refills from the first interval after every restart
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hist      <= '0;
            hist_fill <= 1'b1;
        end else if (beat_accept && !first_beat) begin
            hist      <= hist_nxt;
            hist_fill <= 1'b0;
        end else if (timeout_hit) begin
            hist_fill <= 1'b1;
        end
    end
`else
    assign divisor = ms_since;
`endif

    // Record request and launch selection (pending entry is always older)
    always_comb begin
        req_new         = (beat_accept && !first_beat) || timeout_hit;
        req_rec.timeout  = timeout_hit;
        req_rec.interval = ms_since;
        req_rec.divisor  = divisor;
        can_launch  = (out_q == OUT_IDLE) || (out_q == OUT_ACKLO && !IO_READ_ACK);
        launch_pend = can_launch && pend_valid;
        launch_new  = can_launch && !pend_valid && req_new;
        launch      = launch_pend || launch_new;
        launch_req  = pend_valid ? pend_req : req_rec;
    end

    // Output FSM state register
    always_ff @(posedge HCLK) begin
        if (HRESET) out_q <= OUT_IDLE;
        else        out_q <= out_d;
    end

    // Output FSM next state
    always_comb begin
        out_d = out_q;
        unique case (out_q)
            OUT_IDLE, OUT_ACKLO: begin
                if (launch)
                    out_d = launch_req.timeout ? OUT_RDY : OUT_DIV;
                else if (can_launch)
                    out_d = OUT_IDLE;
            end
            OUT_DIV:  if (div_done)    out_d = OUT_RDY;
            OUT_RDY:  if (IO_READ_ACK) out_d = OUT_ACKLO;
            default:  out_d = OUT_IDLE;
        endcase
    end

    // Output FSM outputs: divider start, record load, RDY
    always_comb begin
        div_start       = 1'b0;
        load_rec        = 1'b0;
        IO_READ_RDY     = 1'b0;
        rec_nxt         = rec_q;
        rec_nxt.overrun = overrun;
        rec_nxt.seq     = seq + 6'd1;
        unique case (out_q)
            OUT_IDLE, OUT_ACKLO: begin
                if (launch) begin
                    if (launch_req.timeout) begin
                        load_rec         = 1'b1;
                        rec_nxt.timeout  = 1'b1;
                        rec_nxt.bpm      = 8'd0;
                        rec_nxt.interval = launch_req.interval;
                    end else begin
                        div_start = 1'b1;
                    end
                end
            end
            OUT_DIV: begin
                if (div_done) begin
                    load_rec         = 1'b1;
                    rec_nxt.timeout  = 1'b0;
                    rec_nxt.bpm      = sat_bpm(div_quo);
                    rec_nxt.interval = cur_interval;
                end
            end
            OUT_RDY: IO_READ_RDY = 1'b1;
            default: ;
        endcase
    end

    // Record register, sequence, pending buffer and overrun sticky
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rec_q        <= '0;
            seq          <= '0;
            overrun      <= 1'b0;
            pend_valid   <= 1'b0;
            pend_req     <= '0;
            cur_interval <= '0;
        end else begin
            if (launch)
                cur_interval <= launch_req.interval;
            if (load_rec) begin
                rec_q   <= rec_nxt;
                seq     <= seq + 6'd1;
                overrun <= 1'b0;
            end
            if (launch_pend) begin
                // Pending slot drains; a same-cycle request refills it
                pend_valid <= req_new;
                pend_req   <= req_rec;
            end else if (req_new && !launch_new) begin
                if (pend_valid)
                    overrun <= 1'b1;
                pend_valid <= 1'b1;
                pend_req   <= req_rec;
            end
        end
    end

    hb_divider #(.W(16)) u_div (
        .clk       (HCLK),
        .rst       (HRESET),
        .start     (div_start),
        .dividend  (16'(BPM_NUMERATOR)),
        .divisor   (launch_req.divisor),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

endmodule

// File: tb/tb_heartbeat_detector.sv
// Scoreboard bench for heartbeat_detector (TICK_DIV=10, so 1 ms = 10 cycles).
// Build with HB_AVG_EN defined to run the averaging sequence instead.
module tb_heartbeat_detector;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        sample_valid = 1'b0;
    logic [11:0] sample = 12'd0;
    logic        IO_READ_ACK = 1'b0;
    logic [31:0] IO_HEARTBEAT;
    logic        IO_READ_RDY;
    logic        beat_pulse;

    heartbeat_detector #(.TICK_DIV(10)) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .sample_valid (sample_valid),
        .sample       (sample),
        .IO_READ_ACK  (IO_READ_ACK),
        .IO_HEARTBEAT (IO_HEARTBEAT),
        .IO_READ_RDY  (IO_READ_RDY),
        .beat_pulse   (beat_pulse)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    int bp_cnt = 0;
    always @(posedge HCLK) cyc <= cyc + 1;
    always @(posedge HCLK) if (beat_pulse) bp_cnt <= bp_cnt + 1;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mexp;
    bit          ack_hold = 1'b0;
    bit          abort_ok = 1'b0;
    int          a;
    int          bp_exp;

    function automatic logic [31:0] mk(input logic ov, input logic to,
                                       input int sq, input int bpm, input int iv);
        logic [5:0]  s;
        logic [7:0]  b;
        logic [15:0] v;
        s = 6'(sq);
        b = 8'(bpm);
        v = 16'(iv);
        return {ov, to, s, b, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Threshold crossing (exactly THRESH_HI) sampled at edge t+1, then re-arm at THRESH_LO
    task automatic hit_at(input int t);
        while (cyc < t) @(negedge HCLK);
        sample = 12'd2600; sample_valid = 1'b1;
        @(negedge HCLK);
        sample_valid = 1'b0;
        @(negedge HCLK);
        @(negedge HCLK);
        sample = 12'd2200; sample_valid = 1'b1;
        @(negedge HCLK);
        sample_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        HRESET = 1'b1;
        @(negedge HCLK);
        check({tag, "_rdy"}, {31'd0, IO_READ_RDY}, 32'd0);
        check({tag, "_heartbeat"}, IO_HEARTBEAT, 32'd0);
        check({tag, "_beat_pulse"}, {31'd0, beat_pulse}, 32'd0);
        @(negedge HCLK);
        HRESET = 1'b0;
    endtask

    // Monitor: compare each presented record, then run the ACK handshake
    initial begin
        forever begin
            @(negedge HCLK);
            if (IO_READ_RDY) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_record: got %h expected none", IO_HEARTBEAT);
                    mexp = IO_HEARTBEAT;
                end else begin
                    mexp = exp_q.pop_front();
                    check("record", IO_HEARTBEAT, mexp);
                end
                while (ack_hold && IO_READ_RDY) @(negedge HCLK);
                if (!IO_READ_RDY) begin
                    if (!abort_ok) begin
                        n_cmp++; n_bad++;
                        $display("FAIL rdy_held: got rdy=0 expected rdy=1 before ack");
                    end
                end else begin
                    check("record_held", IO_HEARTBEAT, mexp);
                    IO_READ_ACK = 1'b1;
                    @(negedge HCLK);
                    check("rdy_fall_after_ack", {31'd0, IO_READ_RDY}, 32'd0);
                    repeat (3) begin
                        @(negedge HCLK);
                        check("rdy_waits_ack_low", {31'd0, IO_READ_RDY}, 32'd0);
                    end
                    IO_READ_ACK = 1'b0;
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge HCLK);
        check("reset_rdy", {31'd0, IO_READ_RDY}, 32'd0);
        check("reset_heartbeat", IO_HEARTBEAT, 32'd0);
        check("reset_beat_pulse", {31'd0, beat_pulse}, 32'd0);
        HRESET = 1'b0;

`ifdef HB_AVG_EN
        // Intervals 500,1000,500,1000 -> divisors 500,625,625,750
        a = cyc + 5;  hit_at(a);
        a += 5001;  exp_q.push_back(mk(0, 0, 1, 120, 500));  hit_at(a);
        a += 10001; exp_q.push_back(mk(0, 0, 2, 96, 1000));  hit_at(a);
        a += 5001;  exp_q.push_back(mk(0, 0, 3, 96, 500));   hit_at(a);
        a += 10001; exp_q.push_back(mk(0, 0, 4, 80, 1000));  hit_at(a);
        bp_exp = 5;
`else
        // First beat only starts timing, then two 750 ms intervals
        a = cyc + 5;  hit_at(a);
        a += 7501; exp_q.push_back(mk(0, 0, 1, 80, 750)); hit_at(a);
        a += 7501; exp_q.push_back(mk(0, 0, 2, 80, 750)); hit_at(a);

        // Crossing at 100 ms is refractory; next at 500 ms counts from the last beat
        hit_at(a + 1001);
        a += 5001; exp_q.push_back(mk(0, 0, 3, 120, 500)); hit_at(a);

        // ACK held low: first record shown, second pending, third overwrites it
        while (cyc < a + 200) @(negedge HCLK);
        ack_hold = 1'b1;
        a += 10001; exp_q.push_back(mk(0, 0, 4, 60, 1000)); hit_at(a);
        a += 5001;  hit_at(a);
        a += 5001;  exp_q.push_back(mk(1, 0, 5, 120, 500)); hit_at(a);
        repeat (50) @(negedge HCLK);
        ack_hold = 1'b0;

        // 3000 ms silence: one timeout record; next beat only restarts timing
        exp_q.push_back(mk(0, 1, 6, 0, 3000));
        a += 30100; hit_at(a);

        // Reset while dividing: record aborted
        a += 2501;  hit_at(a);
        do_reset("div_reset");

        // After reset: 249 ms is refractory, 250 ms is accepted; seq restarts at 1
        ack_hold = 1'b1;
        a = cyc + 5; hit_at(a);
        hit_at(a + 2491);
        a += 2501; exp_q.push_back(mk(0, 0, 1, 240, 250)); hit_at(a);
        for (int i = 0; i < 100 && !IO_READ_RDY; i++) @(negedge HCLK);
        check("rdy_before_reset", {31'd0, IO_READ_RDY}, 32'd1);
        repeat (5) @(negedge HCLK);
        abort_ok = 1'b1;
        do_reset("rdy_reset");
        ack_hold = 1'b0;
        repeat (5) @(negedge HCLK);
        check("rdy_after_reset", {31'd0, IO_READ_RDY}, 32'd0);
        bp_exp = 11;
`endif

        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge HCLK);
        check("records_outstanding", exp_q.size(), 32'd0);
        repeat (10) @(negedge HCLK);
        check("beat_pulse_count", bp_cnt, bp_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
